// File: rtl/rv64g_l1_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rv64g_l1_mem_arbiter
// Two-port round-robin arbiter onto one L1 backing-memory port, with burst
// lock and in-order read-response routing.  Rev 1.0
// ============================================================================
module rv64g_l1_mem_arbiter #(
    parameter int ADDR_W          = 64,
    parameter int DATA_W          = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  m0_req_i,
    input  logic                  m0_we_i,
    input  logic [DATA_W/8-1:0]   m0_be_i,
    input  logic [ADDR_W-1:0]     m0_addr_i,
    input  logic [DATA_W-1:0]     m0_wdata_i,
    input  logic                  m0_lock_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [DATA_W-1:0]     m0_rdata_o,

    input  logic                  m1_req_i,
    input  logic                  m1_we_i,
    input  logic [DATA_W/8-1:0]   m1_be_i,
    input  logic [ADDR_W-1:0]     m1_addr_i,
    input  logic [DATA_W-1:0]     m1_wdata_i,
    input  logic                  m1_lock_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [DATA_W-1:0]     m1_rdata_o,

    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_W/8-1:0]   mem_be_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_W-1:0]     mem_rdata_i,

    output logic                  busy_o,
    output logic                  err_o
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

    logic                       rr_q;
    logic                       lock_q;
    logic                       lock_owner_q;
    logic                       err_q;
    logic [PTR_W-1:0]           wr_ptr_q;
    logic [PTR_W-1:0]           rd_ptr_q;
    logic [CNT_W-1:0]           count_q;
    logic [MAX_OUTSTANDING-1:0] id_fifo_q;

    logic fifo_full;
    logic fifo_empty;
    logic elig0;
    logic elig1;
    logic owner;
    logic owner_elig;
    logic owner_lock;
    logic handshake;
    logic push;
    logic pop;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);

    // A full ID FIFO blocks reads only; there is no same-cycle pop bypass.
    assign elig0 = m0_req_i && (m0_we_i || !fifo_full);
    assign elig1 = m1_req_i && (m1_we_i || !fifo_full);

    always_comb begin
        owner = 1'b0;
        if (lock_q) begin
            owner = lock_owner_q;
        end else if (elig0 && elig1) begin
            owner = rr_q;
        end else begin
            owner = elig1;
        end
    end

    assign owner_elig = owner ? elig1 : elig0;
    assign owner_lock = owner ? m1_lock_i : m0_lock_i;

    assign mem_req_o   = owner_elig;
    assign mem_we_o    = owner ? m1_we_i    : m0_we_i;
    assign mem_be_o    = owner ? m1_be_i    : m0_be_i;
    assign mem_addr_o  = owner ? m1_addr_i  : m0_addr_i;
    assign mem_wdata_o = owner ? m1_wdata_i : m0_wdata_i;

    assign handshake = owner_elig && mem_gnt_i;
    assign m0_gnt_o  = handshake && !owner;
    assign m1_gnt_o  = handshake && owner;

    assign push = handshake && !mem_we_o;
    assign pop  = mem_rvalid_i && !fifo_empty;

    assign m0_rvalid_o = pop && !id_fifo_q[rd_ptr_q];
    assign m1_rvalid_o = pop && id_fifo_q[rd_ptr_q];
    assign m0_rdata_o  = mem_rdata_i;
    assign m1_rdata_o  = mem_rdata_i;

    assign busy_o = !fifo_empty || lock_q;
    assign err_o  = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q         <= 1'b0;
            lock_q       <= 1'b0;
            lock_owner_q <= 1'b0;
            err_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            id_fifo_q    <= '0;
        end else begin
            // Lock is only ever sampled on an accepted beat.
            if (handshake) begin
                rr_q         <= ~owner;
                lock_q       <= owner_lock;
                lock_owner_q <= owner;
            end
            if (push) begin
                id_fifo_q[wr_ptr_q] <= owner;
                wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (mem_rvalid_i && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv64g_l1_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_rv64g_l1_mem_arbiter
// Scoreboard bench: queue-based arbiter model plus in-order response checker.
// Rev 1.0
// ============================================================================
module tb_rv64g_l1_mem_arbiter;

    localparam int MAX_OUT = 4;

    typedef struct {
        logic        we;
        logic [7:0]  be;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        lock;
    } beat_t;

    typedef struct {
        int          port;
        logic [63:0] data;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        m0_req_i = 1'b0, m0_we_i = 1'b0, m0_lock_i = 1'b0;
    logic [7:0]  m0_be_i = '0;
    logic [63:0] m0_addr_i = '0, m0_wdata_i = '0;
    logic        m1_req_i = 1'b0, m1_we_i = 1'b0, m1_lock_i = 1'b0;
    logic [7:0]  m1_be_i = '0;
    logic [63:0] m1_addr_i = '0, m1_wdata_i = '0;
    logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [63:0] mem_rdata_i = '0;
    logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
    logic [63:0] m0_rdata_o, m1_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [7:0]  mem_be_o;
    logic [63:0] mem_addr_o, mem_wdata_o;
    logic        busy_o, err_o;

    rv64g_l1_mem_arbiter #(
        .ADDR_W(64), .DATA_W(64), .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
        .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i), .m0_lock_i(m0_lock_i),
        .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
        .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_lock_i(m1_lock_i),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int    n_chk  = 0;
    int    n_pass = 0;
    beat_t q0[$];
    beat_t q1[$];
    exp_t  exp_q[$];
    logic [63:0] pend[$];
    bit    gnt_rand = 0, rsp_rand = 0, hold_rsp = 0, gap_en = 0, spur_req = 0;

    task automatic chk(string nm, logic [159:0] act, logic [159:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [63:0] memf(logic [63:0] a);
        return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h5A5A_0F0F_3C3C_A5A5;
    endfunction

    function automatic beat_t mk(logic we, logic [63:0] addr, logic lock);
        beat_t b;
        b.we    = we;
        b.be    = we ? 8'($urandom) : 8'hFF;
        b.addr  = addr;
        b.wdata = {$urandom, $urandom};
        b.lock  = lock;
        return b;
    endfunction

    task automatic put(int p, beat_t b);
        if (p == 0) q0.push_back(b);
        else q1.push_back(b);
    endtask

    // Port agents: present the head beat, retire it when granted.
    initial forever begin
        @(posedge clk_i); #1;
        m0_req_i = 1'b0;
        m1_req_i = 1'b0;
        if (q0.size() > 0 && !(gap_en && $urandom_range(0, 4) == 0)) begin
            m0_req_i = 1'b1; m0_we_i = q0[0].we; m0_be_i = q0[0].be;
            m0_addr_i = q0[0].addr; m0_wdata_i = q0[0].wdata; m0_lock_i = q0[0].lock;
        end
        if (q1.size() > 0 && !(gap_en && $urandom_range(0, 4) == 0)) begin
            m1_req_i = 1'b1; m1_we_i = q1[0].we; m1_be_i = q1[0].be;
            m1_addr_i = q1[0].addr; m1_wdata_i = q1[0].wdata; m1_lock_i = q1[0].lock;
        end
    end

    initial forever begin
        @(negedge clk_i);
        if (rst_ni && m0_req_i && m0_gnt_o && q0.size() > 0) q0.delete(0);
        if (rst_ni && m1_req_i && m1_gnt_o && q1.size() > 0) q1.delete(0);
    end

    // Memory model: in-order read responses, unaware of arbiter reset.
    initial forever begin
        @(negedge clk_i);
        if (mem_req_o && mem_gnt_i && !mem_we_o) pend.push_back(mem_addr_o);
    end

    initial forever begin
        @(posedge clk_i); #1;
        mem_gnt_i    = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        mem_rvalid_i = 1'b0;
        if (spur_req) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = {$urandom, $urandom};
            spur_req     = 0;
        end else if (pend.size() > 0 && !hold_rsp && (!rsp_rand || $urandom_range(0, 2) == 0)) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = memf(pend.pop_front());
        end
    end

    // Reference model: priority bit, lock owner and an outstanding-read count.
    int          m_prio = 0, m_lock_owner = 0, m_cnt = 0, win;
    bit          m_locked = 0, m_err = 0;
    bit          rq[2], wr[2], lk[2], el[2];
    logic [7:0]  bes[2];
    logic [63:0] ad[2], wd[2];
    logic [1:0]  exp_g;
    exp_t        new_e;

    initial forever begin
        @(negedge clk_i);
        if (!rst_ni) begin
            m_prio = 0; m_locked = 0; m_lock_owner = 0; m_cnt = 0; m_err = 0;
            exp_q.delete();
            chk("rst_busy", busy_o, 0);
            chk("rst_err", err_o, 0);
            chk("rst_req_gnt", {mem_req_o, m1_gnt_o, m0_gnt_o}, 0);
        end else begin
            rq[0] = m0_req_i; wr[0] = m0_we_i; lk[0] = m0_lock_i;
            bes[0] = m0_be_i; ad[0] = m0_addr_i; wd[0] = m0_wdata_i;
            rq[1] = m1_req_i; wr[1] = m1_we_i; lk[1] = m1_lock_i;
            bes[1] = m1_be_i; ad[1] = m1_addr_i; wd[1] = m1_wdata_i;
            for (int p = 0; p < 2; p++) el[p] = rq[p] && (wr[p] || m_cnt < MAX_OUT);
            win = -1;
            if (m_locked) begin
                if (el[m_lock_owner]) win = m_lock_owner;
            end else begin
                for (int k = 0; k < 2; k++)
                    if (win < 0 && el[(m_prio + k) % 2]) win = (m_prio + k) % 2;
            end
            exp_g = 2'b00;
            if (win >= 0 && mem_gnt_i) exp_g = (win == 0) ? 2'b01 : 2'b10;
            chk("gnt", {m1_gnt_o, m0_gnt_o}, exp_g);
            chk("mem_req", mem_req_o, win >= 0);
            if (win >= 0)
                chk("mem_bus", {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o},
                    {wr[win], bes[win], ad[win], wd[win]});
            chk("busy", busy_o, (m_cnt != 0) || m_locked);
            chk("err", err_o, m_err);
            chk("rvalid_any", m0_rvalid_o | m1_rvalid_o, mem_rvalid_i && m_cnt > 0);
            if (mem_rvalid_i) begin
                if (m_cnt > 0) m_cnt--;
                else m_err = 1;
            end
            if (win >= 0 && mem_gnt_i) begin
                m_prio = 1 - win;
                if (!wr[win]) begin
                    m_cnt++;
                    new_e.port = win;
                    new_e.data = memf(ad[win]);
                    exp_q.push_back(new_e);
                end
                m_locked     = lk[win];
                m_lock_owner = win;
            end
        end
    end

    exp_t mon_e;
    initial forever begin
        @(negedge clk_i); #1;
        if (m0_rvalid_o || m1_rvalid_o) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", {m1_rvalid_o, m0_rvalid_o}, 2'b00);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_port", {m1_rvalid_o, m0_rvalid_o}, (mon_e.port == 0) ? 2'b01 : 2'b10);
                chk("rsp_data", (mon_e.port == 0) ? m0_rdata_o : m1_rdata_o, mon_e.data);
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin @(negedge clk_i); #2; end
    endtask

    task automatic do_reset();
        q0.delete();
        q1.delete();
        @(posedge clk_i); #2 rst_ni = 1'b0;
        @(posedge clk_i); #2 rst_ni = 1'b1;
        @(negedge clk_i); #2;
    endtask

    task automatic drain(string nm);
        int k = 0;
        while ((q0.size() > 0 || q1.size() > 0 || pend.size() > 0 || exp_q.size() > 0) && k < 300) begin
            step(1);
            k++;
        end
        step(2);
        chk(nm, k < 300, 1'b1);
    endtask

    initial begin
        #1 rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        @(posedge clk_i); #2 rst_ni = 1'b1;
        step(1);

        // Simultaneous reads, 1-cycle memory
        put(0, mk(1'b0, 64'h100, 1'b0));
        put(1, mk(1'b0, 64'h200, 1'b0));
        drain("drain_reads");

        // Alternating writes
        for (int i = 0; i < 4; i++) begin
            put(0, mk(1'b1, 64'h1000 + 64'(i * 8), 1'b0));
            put(1, mk(1'b1, 64'h2000 + 64'(i * 8), 1'b0));
        end
        drain("drain_writes");

        // Locked 8-beat burst on m1 while m0 contends
        for (int i = 0; i < 8; i++) put(1, mk(1'b1, 64'h3000 + 64'(i * 8), i < 7));
        step(1);
        for (int i = 0; i < 3; i++) put(0, mk(1'b1, 64'h4000 + 64'(i * 8), 1'b0));
        drain("drain_burst");

        // Full ID FIFO blocks reads but not writes
        hold_rsp = 1;
        for (int i = 0; i < 5; i++) put(0, mk(1'b0, 64'h5000 + 64'(i * 8), 1'b0));
        for (int i = 0; i < 6; i++) put(1, mk(1'b1, 64'h6000 + 64'(i * 8), 1'b0));
        step(14);
        hold_rsp = 0;
        drain("drain_full");

        // Spurious response
        step(2);
        spur_req = 1;
        step(5);
        do_reset();

        // Reset while locked with reads outstanding
        hold_rsp = 1;
        put(0, mk(1'b0, 64'h7000, 1'b0));
        put(0, mk(1'b0, 64'h7008, 1'b0));
        step(3);
        for (int i = 0; i < 6; i++) put(1, mk(1'b1, 64'h8000 + 64'(i * 8), 1'b1));
        step(3);
        do_reset();
        put(0, mk(1'b1, 64'h9000, 1'b0));
        put(1, mk(1'b1, 64'h9100, 1'b0));
        step(3);
        hold_rsp = 0;
        drain("drain_stale");
        step(2);
        do_reset();

        // Randomized traffic
        gnt_rand = 1; rsp_rand = 1; gap_en = 1;
        for (int c = 0; c < 800; c++) begin
            if (q0.size() < 3 && $urandom_range(0, 2) == 0)
                put(0, mk(1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom_range(0, 3) == 0));
            if (q1.size() < 3 && $urandom_range(0, 2) == 0)
                put(1, mk(1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom_range(0, 3) == 0));
            step(1);
        end
        put(0, mk(1'b1, 64'hA000, 1'b0));
        put(1, mk(1'b1, 64'hA100, 1'b0));
        drain("drain_random");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/rv64g_l1_mem_arbiter.md
Name: rv64g_l1_mem_arbiter

Overview:
Two-requester arbiter sharing one 64-bit L1 backing-memory port (req/gnt request channel, rvalid/rdata response channel). It sits between the L1 requesters (port m0 and port m1, e.g. I-side and D-side refill/writeback engines) and the memory model or L2 port. It provides round-robin grant, multi-beat lock for line bursts, and in-order read-response routing through an outstanding-read ID FIFO.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width; byte-enable width BE_W = DATA_W/8
MAX_OUTSTANDING, 4, depth of the read-ID FIFO; power of two, at least 2

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
mX_req_i  in  1  request from port mX, where X is 0 or 1 (applies to every mX_* port below)
mX_we_i  in  1  1 = write, 0 = read
mX_be_i  in  BE_W  byte enables
mX_addr_i  in  ADDR_W  byte address
mX_wdata_i  in  DATA_W  write data
mX_lock_i  in  1  hold the grant after this beat (burst continues)
mX_gnt_o  out  1  request accepted this cycle
mX_rvalid_o  out  1  read response for mX
mX_rdata_o  out  DATA_W  response data (mem_rdata_i is broadcast to both ports)
mem_req_o  out  1  downstream request
mem_we_o  out  1  downstream write enable
mem_be_o  out  BE_W  downstream byte enables
mem_addr_o  out  ADDR_W  downstream address
mem_wdata_o  out  DATA_W  downstream write data
mem_gnt_i  in  1  downstream accept
mem_rvalid_i  in  1  downstream read response valid
mem_rdata_i  in  DATA_W  downstream read data
busy_o  out  1  high when outstanding count is non-zero or the lock is held
err_o  out  1  sticky; set when a response arrives with no outstanding read

Behaviour:
- State: rr_q (1b, the port with priority), lock_q, lock_owner_q, a read-ID FIFO (wr_ptr, rd_ptr, count with range 0..MAX_OUTSTANDING), err_q.
- Reset values: rr_q=0 (m0 has priority), lock_q=0, count=0, pointers=0, err_q=0.
- Outputs during reset: all gnt/rvalid outputs and mem_req_o are 0 whenever their inputs are 0.
- Eligibility: mX is eligible when mX_req_i && (mX_we_i || count != MAX_OUTSTANDING). There is no pop bypass: a full FIFO blocks reads even when mem_rvalid_i is high in the same cycle.
- Arbiter state UNLOCKED (lock_q=0):
  - Exactly one port eligible: owner = that port.
  - Both ports eligible: owner = rr_q.
  - Neither eligible: mem_req_o=0.
- Arbiter state LOCKED (lock_q=1):
  - owner = lock_owner_q; only the owner can be eligible.
  - If the owner has no eligible request, mem_req_o=0 and the arbiter stays LOCKED.
- Request path is combinational, zero added latency:
  - mem_* = owner's signals, mem_req_o = owner eligible.
  - owner_gnt_o = mem_gnt_i && mem_req_o; the other port's gnt = 0.
- On handshake (mem_req_o && mem_gnt_i):
  - rr_q <= ~owner.
  - A read pushes the owner ID into the FIFO.
  - If owner lock_i=1: lock_q <= 1 and lock_owner_q <= owner (UNLOCKED -> LOCKED, or stay LOCKED).
  - If owner lock_i=0: lock_q <= 0 (LOCKED -> UNLOCKED).
- Lock is sampled only at handshakes. Dropping lock without a handshake has no effect.
- Response path is combinational: on mem_rvalid_i with count>0, the head ID selects which mX_rvalid_o is pulsed, and the head is popped.
- Spurious response: mem_rvalid_i with count=0 drives no rvalid, sets err_q, leaves count at 0. err_q clears only on reset.
- Push and pop in the same cycle: count unchanged, both pointers advance; pointers wrap modulo MAX_OUTSTANDING.
- Writes never enter the FIFO; writes are never blocked by a full FIFO.
- Reset asserted mid-operation: lock and FIFO are discarded immediately. Responses arriving after reset for requests issued before it set err_o.
- busy_o = (count != 0) || lock_q.

Test Plan:
- Both ports reset to idle; both read in cycle 0 (m0 addr 0x100, m1 addr 0x200) with a 1-cycle-latency memory holding mem[0x20]=A and mem[0x40]=B, gnt=req.
  -> cycle 0: m0_gnt=1, m1_gnt=0.
  -> cycle 1: m1_gnt=1, m0_rvalid=1 with rdata=A.
  -> cycle 2: m1_rvalid=1 with rdata=B.
- Both ports hold write requests continuously for 8 cycles -> grants alternate m0,m1,m0,...; 4 grants each; never two grants in one cycle.
- m1 issues an 8-beat write burst with lock=1 on beats 1-7 and lock=0 on beat 8, while m0 requests throughout.
  -> m1 is granted 8 consecutive cycles and m0_gnt=0 throughout.
  -> m0 is granted the cycle after beat 8; busy_o falls once the burst ends.
- MAX_OUTSTANDING=4, memory rvalid withheld: m0 issues 5 reads and m1 issues writes.
  -> after 4 m0 reads are accepted, m0 read is ineligible while m1 writes are still granted.
  -> after one rvalid pops the FIFO, m0 read is granted the next cycle.
- mem_rvalid_i pulsed with count=0 -> both rvalid outputs stay 0, err_o=1 and stays 1 until rst_ni is pulsed.
- rst_ni pulsed low mid-burst while LOCKED with 2 reads outstanding.
  -> lock_q=0, count=0, busy_o=0, rr_q=0.
  -> the next response raises err_o.
